// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch front end. It issues one instruction-memory read at a time
// and queues the returned words, each with its address, in a 2-entry FIFO
// that feeds decode. A flush discards every queued word. A flush that arrives
// while a read is in flight lets that read finish on the bus and then drops
// its data.
//
// Ports
//   clock        single clock; all state updates on the rising edge
//   reset        asynchronous, active-high
//   pc_in        current PC from the PC register
//   pc_load      one-cycle pulse telling the PC register to advance
//   flush        redirect taken; drop buffered and in-flight fetches
//   imem_req     instruction memory read request (held until imem_ack)
//   imem_addr    read address (held until imem_ack)
//   imem_ack     memory returns imem_rdata this cycle
//   imem_rdata   returned instruction word
//   instr        head instruction word
//   instr_pc     address of the head instruction
//   instr_valid  the FIFO holds at least one entry
//   instr_ready  decode accepts the head entry this cycle
//   misalign     pc_in is not word aligned, so no fetch can start
// ---------------------------------------------------------------------------
module fetch_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] pc_in,
  output logic        pc_load,
  input  logic        flush,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [63:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        misalign
);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t      state;
  logic [31:0] fifo_instr [2];
  logic [63:0] fifo_pc    [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;

  logic issue;
  logic push;
  logic pop;

  // A read starts only from IDLE. Because of that, a read can be in flight
  // only when the FIFO had room when the read began. Pops can only free
  // space, so a returning read never finds the FIFO full.
  assign issue = (state == IDLE) && (count < 2'd2) && !flush && (pc_in[1:0] == 2'b00);

  // Only a read that is still wanted deposits its data. A flush in the ack
  // cycle cancels the deposit and the PC advance together.
  assign push    = (state == WAIT) && imem_ack && !flush;
  assign pc_load = push;

  assign pop         = instr_valid && instr_ready;
  assign instr_valid = (count != 2'd0);
  assign instr       = fifo_instr[rd_ptr];
  assign instr_pc    = fifo_pc[rd_ptr];
  assign misalign    = (state == IDLE) && (pc_in[1:0] != 2'b00);

  // Request FSM. imem_req and imem_addr are registered and stay constant from
  // issue until the ack edge, so the memory sees one stable request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      imem_req  <= 1'b0;
      imem_addr <= 64'd0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            state     <= WAIT;
            imem_req  <= 1'b1;
            imem_addr <= pc_in;
          end
        end
        WAIT: begin
          if (imem_ack) begin
            state    <= IDLE;
            imem_req <= 1'b0;
          end else if (flush) begin
            state <= DROP;
          end
        end
        DROP: begin
          if (imem_ack) begin
            state    <= IDLE;
            imem_req <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  // Two-entry circular FIFO. With one entry queued, a push and a pop in the
  // same cycle write the free slot and advance the read side, so the order
  // of entries is kept. A flush overrides any pop in the same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_instr[i] <= 32'd0;
        fifo_pc[i]    <= 64'd0;
      end
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        fifo_instr[wr_ptr] <= imem_rdata;
        fifo_pc[wr_ptr]    <= imem_addr;
        wr_ptr             <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Self-checking bench for fetch_unit. The reference model is a queue of
// fetched {word, address} entries plus a record of any read still in flight.
// Each cycle the model predicts every output, and the bench compares the DUT
// outputs with those predictions. Directed tables and sequences also check
// hand-derived values. A randomized run follows them.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clock;
  logic        reset;
  logic [63:0] pc_in;
  logic        pc_load;
  logic        flush;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        misalign;

  fetch_unit dut (
    .clock       (clock),
    .reset       (reset),
    .pc_in       (pc_in),
    .pc_load     (pc_load),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .misalign    (misalign)
  );

  // Free-running clock; rising edges at 5, 15, 25, ...
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: the queue of fetched entries, whether a read is in
  // flight, whether its data is to be discarded, and the last issued address.
  typedef struct packed {
    logic [31:0] word;
    logic [63:0] addr;
  } entry_t;

  entry_t      mq[$];
  bit          outstanding;
  bit          discard;
  logic [63:0] req_addr;
  bit          last_exp_pl;

  typedef struct {
    logic [63:0] pc;
    logic        fl;
    logic        ak;
    logic [31:0] rd;
    logic        rdy;
    logic        e_req;
    logic [63:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [63:0] e_ipc;
    logic        e_pl;
  } vec_t;

  vec_t tbl[8];

  function automatic bit fieldBad(input string tag, input string fld,
                                  input logic [63:0] act, input logic [63:0] exp);
    if (act !== exp) begin
      $display("[TB] FAIL %s/%s: got %0h expected %0h at %0t", tag, fld, act, exp, $time);
      return 1'b1;
    end
    return 1'b0;
  endfunction

  // Single comparison of one DUT value against a bench-derived expectation.
  task automatic checkVal(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (fieldBad(tag, "value", act, exp)) miscompares++;
  endtask

  // Compare every output against the model's prediction for the current cycle.
  task automatic checkOutput(input string tag);
    bit   bad;
    logic e_pl;
    logic e_mis;
    logic e_valid;
    bad     = 1'b0;
    e_pl    = outstanding && !discard && imem_ack && !flush;
    e_mis   = !outstanding && (pc_in[1:0] != 2'b00);
    e_valid = (mq.size() != 0);
    vectors++;
    bad |= fieldBad(tag, "imem_req", {63'd0, imem_req}, {63'd0, outstanding});
    bad |= fieldBad(tag, "imem_addr", imem_addr, req_addr);
    bad |= fieldBad(tag, "pc_load", {63'd0, pc_load}, {63'd0, e_pl});
    bad |= fieldBad(tag, "misalign", {63'd0, misalign}, {63'd0, e_mis});
    bad |= fieldBad(tag, "instr_valid", {63'd0, instr_valid}, {63'd0, e_valid});
    if (e_valid) begin
      bad |= fieldBad(tag, "instr", {32'd0, instr}, {32'd0, mq[0].word});
      bad |= fieldBad(tag, "instr_pc", instr_pc, mq[0].addr);
    end
    if (bad) miscompares++;
    last_exp_pl = e_pl;
  endtask

  // Advance the model across a rising edge, using the inputs held that cycle.
  task automatic updateModel();
    int     cnt;
    bit     pl;
    entry_t e;
    cnt = mq.size();
    pl  = outstanding && !discard && imem_ack && !flush;
    if (flush) begin
      mq.delete();
    end else begin
      if (cnt != 0 && instr_ready) void'(mq.pop_front());
      if (pl) begin
        e.word = imem_rdata;
        e.addr = req_addr;
        mq.push_back(e);
      end
    end
    if (outstanding) begin
      if (imem_ack) begin
        outstanding = 1'b0;
        discard     = 1'b0;
      end else if (flush) begin
        discard = 1'b1;
      end
    end else if (!flush && pc_in[1:0] == 2'b00 && cnt < 2) begin
      outstanding = 1'b1;
      discard     = 1'b0;
      req_addr    = pc_in;
    end
  endtask

  task automatic modelReset();
    mq.delete();
    outstanding = 1'b0;
    discard     = 1'b0;
    req_addr    = 64'd0;
  endtask

  // Drive one cycle's inputs and check against the model at the falling edge.
  task automatic applyStimulus(input logic [63:0] pc, input logic fl, input logic ak,
                               input logic [31:0] rd, input logic rdy, input string tag);
    pc_in       = pc;
    flush       = fl;
    imem_ack    = ak;
    imem_rdata  = rd;
    instr_ready = rdy;
    @(negedge clock);
    checkOutput(tag);
  endtask

  task automatic endCycle();
    @(posedge clock);
    updateModel();
    #1;
  endtask

  task automatic doReset();
    reset       = 1'b1;
    pc_in       = 64'd0;
    flush       = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = 32'd0;
    instr_ready = 1'b0;
    modelReset();
    @(negedge clock);
    checkOutput("reset");
    checkVal("reset instr", {32'd0, instr}, 64'd0);
    checkVal("reset instr_pc", instr_pc, 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [63:0] pc_reg;
    bit          fl;

    // Basic fetch followed by a back-to-back fetch and a flush of the queue.
    tbl[0] = '{64'h0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 64'h0, 1'b0, 32'h0,        64'h0, 1'b0};
    tbl[1] = '{64'h0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 64'h0, 1'b0, 32'h0,        64'h0, 1'b0};
    tbl[2] = '{64'h0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 64'h0, 1'b0, 32'h0,        64'h0, 1'b0};
    tbl[3] = '{64'h0, 1'b0, 1'b1, 32'h8B020020, 1'b1, 1'b1, 64'h0, 1'b0, 32'h0,        64'h0, 1'b1};
    tbl[4] = '{64'h4, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 64'h0, 1'b1, 32'h8B020020, 64'h0, 1'b0};
    tbl[5] = '{64'h4, 1'b0, 1'b1, 32'h11111111, 1'b1, 1'b1, 64'h4, 1'b0, 32'h0,        64'h0, 1'b1};
    tbl[6] = '{64'h8, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 64'h4, 1'b1, 32'h11111111, 64'h4, 1'b0};
    tbl[7] = '{64'h8, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 64'h4, 1'b0, 32'h0,        64'h0, 1'b0};

    reset = 1'b1;
    doReset();

    for (int i = 0; i < 8; i++) begin
      applyStimulus(tbl[i].pc, tbl[i].fl, tbl[i].ak, tbl[i].rd, tbl[i].rdy, "table");
      checkVal("tbl imem_req", {63'd0, imem_req}, {63'd0, tbl[i].e_req});
      checkVal("tbl imem_addr", imem_addr, tbl[i].e_addr);
      checkVal("tbl instr_valid", {63'd0, instr_valid}, {63'd0, tbl[i].e_valid});
      checkVal("tbl pc_load", {63'd0, pc_load}, {63'd0, tbl[i].e_pl});
      if (tbl[i].e_valid) begin
        checkVal("tbl instr", {32'd0, instr}, {32'd0, tbl[i].e_instr});
        checkVal("tbl instr_pc", instr_pc, tbl[i].e_ipc);
      end
      endCycle();
    end

    // Backpressure: two entries fill the FIFO, no third read, then drain in order.
    doReset();
    applyStimulus(64'h0, 1'b0, 1'b0, 32'h0,        1'b0, "bp"); endCycle();
    applyStimulus(64'h0, 1'b0, 1'b1, 32'hAAAA0000, 1'b0, "bp"); endCycle();
    applyStimulus(64'h4, 1'b0, 1'b0, 32'h0,        1'b0, "bp"); endCycle();
    applyStimulus(64'h4, 1'b0, 1'b1, 32'hBBBB0004, 1'b0, "bp"); endCycle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(64'h8, 1'b0, 1'b0, 32'h0, 1'b0, "bp");
      checkVal("bp no third req", {63'd0, imem_req}, 64'd0);
      checkVal("bp held valid", {63'd0, instr_valid}, 64'd1);
      endCycle();
    end
    applyStimulus(64'h8, 1'b0, 1'b0, 32'h0, 1'b1, "bp");
    checkVal("bp pop0 pc", instr_pc, 64'h0);
    checkVal("bp pop0 instr", {32'd0, instr}, 64'hAAAA0000);
    endCycle();
    applyStimulus(64'h8, 1'b0, 1'b0, 32'h0, 1'b1, "bp");
    checkVal("bp pop1 pc", instr_pc, 64'h4);
    checkVal("bp pop1 instr", {32'd0, instr}, 64'hBBBB0004);
    endCycle();
    applyStimulus(64'h8, 1'b0, 1'b0, 32'h0, 1'b1, "bp");
    checkVal("bp drained", {63'd0, instr_valid}, 64'd0);
    checkVal("bp next req", imem_addr, 64'h8);
    endCycle();

    // Flush while waiting: the read completes on the bus and its data is dropped.
    doReset();
    applyStimulus(64'h10, 1'b0, 1'b0, 32'h0, 1'b1, "fw"); endCycle();
    applyStimulus(64'h10, 1'b1, 1'b0, 32'h0, 1'b1, "fw");
    checkVal("fw addr at flush", imem_addr, 64'h10);
    endCycle();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(64'h10, 1'b0, 1'b0, 32'h0, 1'b1, "fw");
      checkVal("fw addr held", imem_addr, 64'h10);
      checkVal("fw req held", {63'd0, imem_req}, 64'd1);
      endCycle();
    end
    applyStimulus(64'h10, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1, "fw");
    checkVal("fw no pc_load", {63'd0, pc_load}, 64'd0);
    endCycle();
    applyStimulus(64'h13, 1'b0, 1'b0, 32'h0, 1'b1, "fw");
    checkVal("fw idle req", {63'd0, imem_req}, 64'd0);
    checkVal("fw no push", {63'd0, instr_valid}, 64'd0);
    endCycle();

    // Flush with a full FIFO and a stray ack in the same cycle.
    doReset();
    applyStimulus(64'h0, 1'b0, 1'b0, 32'h0,        1'b0, "ff"); endCycle();
    applyStimulus(64'h0, 1'b0, 1'b1, 32'h12345678, 1'b0, "ff"); endCycle();
    applyStimulus(64'h4, 1'b0, 1'b0, 32'h0,        1'b0, "ff"); endCycle();
    applyStimulus(64'h4, 1'b0, 1'b1, 32'h9ABCDEF0, 1'b0, "ff"); endCycle();
    applyStimulus(64'h8, 1'b1, 1'b1, 32'h55555555, 1'b1, "ff");
    checkVal("ff pc_load", {63'd0, pc_load}, 64'd0);
    endCycle();
    applyStimulus(64'h8, 1'b0, 1'b0, 32'h0, 1'b0, "ff");
    checkVal("ff emptied", {63'd0, instr_valid}, 64'd0);
    endCycle();

    // Misaligned PC blocks fetch until an aligned PC arrives.
    doReset();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(64'h6, 1'b0, 1'b0, 32'h0, 1'b1, "mis");
      checkVal("mis flag", {63'd0, misalign}, 64'd1);
      checkVal("mis no req", {63'd0, imem_req}, 64'd0);
      endCycle();
    end
    applyStimulus(64'h8, 1'b0, 1'b0, 32'h0, 1'b1, "mis");
    checkVal("mis cleared", {63'd0, misalign}, 64'd0);
    endCycle();
    applyStimulus(64'h8, 1'b0, 1'b0, 32'h0, 1'b1, "mis");
    checkVal("mis req", {63'd0, imem_req}, 64'd1);
    checkVal("mis addr", imem_addr, 64'h8);
    endCycle();

    // Asynchronous reset between edges while a read is in flight.
    doReset();
    applyStimulus(64'h0, 1'b0, 1'b0, 32'h0,        1'b0, "ar"); endCycle();
    applyStimulus(64'h0, 1'b0, 1'b1, 32'hCAFEF00D, 1'b0, "ar"); endCycle();
    applyStimulus(64'h4, 1'b0, 1'b0, 32'h0,        1'b0, "ar"); endCycle();
    #2;
    reset = 1'b1;
    #1;
    checkVal("ar req dropped", {63'd0, imem_req}, 64'd0);
    checkVal("ar valid dropped", {63'd0, instr_valid}, 64'd0);
    checkVal("ar addr cleared", imem_addr, 64'd0);
    reset = 1'b0;
    modelReset();
    applyStimulus(64'h7, 1'b0, 1'b1, 32'hBAADBAAD, 1'b1, "ar"); endCycle();
    applyStimulus(64'h7, 1'b0, 1'b0, 32'h0,        1'b1, "ar");
    checkVal("ar stray ack", {63'd0, instr_valid}, 64'd0);
    endCycle();

    // Randomized traffic: PC advances on pc_load, redirects on flush.
    doReset();
    pc_reg = 64'h1000;
    for (int i = 0; i < 3000; i++) begin
      fl = ($urandom_range(0, 9) == 0);
      applyStimulus(pc_reg, fl, ($urandom_range(0, 2) == 0), $urandom(),
                    ($urandom_range(0, 1) == 1), "rand");
      endCycle();
      if (fl) begin
        pc_reg      = {$urandom(), $urandom()};
        pc_reg[1:0] = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
      end else if (last_exp_pl) begin
        pc_reg = pc_reg + 64'd4;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
